// File: rtl/pmp_checker_pipe.sv
// Two-stage PMP checker with a shadowed copy of the PMP configuration.
// Define PMP_VIOLATION_CNT_EN to enable the saturating denied-response counter.
// Each conf_i entry is pmpcfg_t: {L, 2'b reserved, A[1:0], X, W, R}.
// Access is {X, W, R} and privilege is U=0, S=1, M=3.
module pmp_checker_pipe #(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 16,
  localparam int unsigned IdxW      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
  localparam int unsigned NrCfg     = (NR_ENTRIES > 0) ? NR_ENTRIES : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PLEN-1:0]    req_addr_i,
  input  logic [1:0]         req_size_i,
  input  logic [2:0]         req_access_i,
  input  logic [1:0]         req_priv_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_allow_o,
  output logic               rsp_hit_o,
  output logic [IdxW-1:0]    rsp_idx_o,
  input  logic [PMP_LEN-1:0] conf_addr_i [NrCfg],
  input  logic [7:0]         conf_i [NrCfg],
  input  logic               cfg_update_i,
  output logic [15:0]        viol_cnt_o
);

  localparam int unsigned AW = PLEN + 1;
  localparam logic [1:0] PrivM     = 2'b11;
  localparam logic [1:0] ModeTor   = 2'd1;
  localparam logic [1:0] ModeNa4   = 2'd2;
  localparam logic [1:0] ModeNapot = 2'd3;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e             state_q;
  logic [PMP_LEN-1:0] sh_addr_q [NrCfg];
  logic [5:0]         sh_cfg_q  [NrCfg];  // {L, A[1:0], X, W, R}

  logic            s1_valid_q;
  logic [PLEN-1:0] s1_addr_q;
  logic [1:0]      s1_size_q;
  logic [2:0]      s1_access_q;
  logic [1:0]      s1_priv_q;

  logic            s2_valid_q;
  logic            rsp_allow_q;
  logic            rsp_hit_q;
  logic [IdxW-1:0] rsp_idx_q;

  logic s2_drain, s1_adv, accept, pipe_empty, load_shadow;
  logic unused_rsvd;

  assign s2_drain    = s2_valid_q & rsp_ready_i;
  assign s1_adv      = s1_valid_q & (~s2_valid_q | s2_drain);
  assign req_ready_o = (state_q == StIdle) & (~s1_valid_q | s1_adv);
  assign accept      = req_valid_i & req_ready_o;
  assign pipe_empty  = ~s1_valid_q & ~s2_valid_q;
  // A reload coinciding with an accept must wait so that request sees the old config.
  assign load_shadow = pipe_empty & ((state_q == StPending) | (cfg_update_i & ~accept));

  always_comb begin
    unused_rsvd = 1'b0;
    for (int i = 0; i < int'(NrCfg); i++) begin
      unused_rsvd = unused_rsvd ^ (^conf_i[i][6:5]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(NrCfg); i++) begin
        sh_addr_q[i] <= '0;
        sh_cfg_q[i]  <= '0;
      end
    end else begin
      if (load_shadow) begin
        for (int i = 0; i < int'(NrCfg); i++) begin
          sh_addr_q[i] <= conf_addr_i[i];
          sh_cfg_q[i]  <= {conf_i[i][7], conf_i[i][4:0]};
        end
      end
      unique case (state_q)
        StIdle:    if (cfg_update_i && !load_shadow) state_q <= StPending;
        StPending: if (load_shadow) state_q <= StIdle;
      endcase
    end
  end

  // Request byte span [req_lo, req_hi), one extra bit so the top of memory fits.
  logic [AW-1:0]    req_lo, req_hi;
  logic [NrCfg-1:0] ent_full, ent_part;

  assign req_lo = AW'(s1_addr_q);
  assign req_hi = req_lo + (AW'(1) << s1_size_q);

  if (NR_ENTRIES == 0) begin : g_no_ent
    assign ent_full = '0;
    assign ent_part = '0;
  end else begin : g_ent
    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_e
      logic [AW-1:0]      base, tor_lo, nmask, lo, hi;
      logic [PMP_LEN-1:0] ones;

      assign base  = AW'({sh_addr_q[i], 2'b00});
      // Trailing ones of pmpaddr plus the first zero give the NAPOT size mask.
      assign ones  = sh_addr_q[i] ^ (sh_addr_q[i] + PMP_LEN'(1));
      assign nmask = AW'({ones, 2'b11});

      if (i == 0) begin : g_first
        assign tor_lo = '0;
      end else begin : g_rest
        assign tor_lo = AW'({sh_addr_q[i-1], 2'b00});
      end

      always_comb begin
        unique case (sh_cfg_q[i][4:3])
          ModeTor: begin
            lo = tor_lo;
            hi = base;
          end
          ModeNa4: begin
            lo = base;
            hi = base + AW'(4);
          end
          ModeNapot: begin
            lo = base & ~nmask;
            hi = (base & ~nmask) + nmask + AW'(1);
          end
          default: begin
            lo = '0;
            hi = '0;
          end
        endcase
      end

      assign ent_full[i] = (lo < hi) && (req_lo >= lo) && (req_hi <= hi);
      assign ent_part[i] = (lo < hi) && (req_lo < hi) && (req_hi > lo) && !ent_full[i];
    end
  end

  logic            chk_allow, chk_hit;
  logic [IdxW-1:0] chk_idx;

  always_comb begin
    chk_allow = (NR_ENTRIES == 0) ? 1'b1 : (s1_priv_q == PrivM);
    chk_hit   = 1'b0;
    chk_idx   = '0;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
      if ((ent_full[i] || ent_part[i]) && (s1_priv_q != PrivM || sh_cfg_q[i][5])) begin
        chk_hit   = 1'b1;
        chk_idx   = IdxW'(i);
        chk_allow = ent_full[i] && ((s1_access_q & sh_cfg_q[i][2:0]) == s1_access_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_size_q   <= '0;
      s1_access_q <= '0;
      s1_priv_q   <= '0;
      s2_valid_q  <= 1'b0;
      rsp_allow_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      if (accept) begin
        s1_valid_q  <= 1'b1;
        s1_addr_q   <= req_addr_i;
        s1_size_q   <= req_size_i;
        s1_access_q <= req_access_i;
        s1_priv_q   <= req_priv_i;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid_q  <= 1'b1;
        rsp_allow_q <= chk_allow;
        rsp_hit_q   <= chk_hit;
        rsp_idx_q   <= chk_idx;
      end else if (s2_drain) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = s2_valid_q;
  assign rsp_allow_o = rsp_allow_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_idx_o   = rsp_idx_q;

`ifdef PMP_VIOLATION_CNT_EN
  logic [15:0] viol_cnt_q, viol_cnt_d;

  always_comb begin
    viol_cnt_d = viol_cnt_q;
    if (s2_drain && !rsp_allow_q && viol_cnt_q != 16'hFFFF) begin
      viol_cnt_d = viol_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) viol_cnt_q <= '0;
    else         viol_cnt_q <= viol_cnt_d;
  end

  assign viol_cnt_o = viol_cnt_q;
`else
  assign viol_cnt_o = '0;
`endif

endmodule

// File: doc/pmp_checker_pipe.md
PMP_CHECKER_PIPE -- requirements
Module: pmp_checker_pipe

Interface
REQ-001 SHALL have parameter PLEN, default 34, physical address width.
REQ-002 SHALL have parameter PMP_LEN, default 32, pmpaddr width (addr bits [PLEN-1:2]).
REQ-003 SHALL have parameter NR_ENTRIES, default 16, legal range 0..64, number of PMP entries.
REQ-004 SHALL have ports clk_i in 1, rising-edge clock; rst_ni in 1, reset, synchronous, active-low.
REQ-005 SHALL have ports req_valid_i in 1, request valid; req_ready_o out 1, request accepted when both high.
REQ-006 SHALL have ports req_addr_i in PLEN, byte address; req_size_i in 2, log2 access bytes (0..3); req_access_i in 3, riscv::pmp_access_t; req_priv_i in 2, riscv::priv_lvl_t.
REQ-007 SHALL have ports rsp_valid_o out 1, response valid; rsp_ready_i in 1, response consumed when both high.
REQ-008 SHALL have ports rsp_allow_o out 1, grant; rsp_hit_o out 1, some entry matched; rsp_idx_o out max(1,$clog2(NR_ENTRIES)), matching entry index.
REQ-009 SHALL have ports conf_addr_i in NR_ENTRIES x PMP_LEN; conf_i in NR_ENTRIES x riscv::pmpcfg_t; cfg_update_i in 1, pulse requesting shadow reload.
REQ-010 SHALL have port viol_cnt_o out 16, denied-response count (see Configuration).

Function
REQ-011 SHALL be a two-stage pipeline: S1 registers accepted request, S2 registers the check result; rsp_valid_o rises exactly 2 cycles after acceptance when rsp_ready_i held high.
REQ-012 SHALL sustain one accepted request per cycle with no bubbles when rsp_ready_i stays high.
REQ-013 SHALL advance S1->S2 only when S2 empty or S2 draining same cycle; req_ready_o = !pending & (S1 empty or S1 advancing).
REQ-014 SHALL hold all S2 outputs stable while rsp_valid_o & !rsp_ready_i.
REQ-015 SHALL decode OFF/TOR/NA4/NAPOT per entry; TOR entry 0 lower bound is 0; TOR with lower >= upper matches nothing.
REQ-016 SHALL evaluate checks against shadow config registers, never live conf_i.
REQ-017 SHALL declare entry i a full hit when all bytes addr..addr+2^size-1 lie in region i, partial hit when only some do.
REQ-018 SHALL select the lowest-index entry with full or partial hit that is applicable (priv != M, or locked); partial hit SHALL deny with rsp_hit_o=1.
REQ-019 SHALL allow on full hit iff (req_access & cfg.access_type) == req_access.
REQ-020 SHALL, with no applicable hit, allow iff priv == M; rsp_hit_o=0, rsp_idx_o=0.
REQ-021 SHALL, when NR_ENTRIES==0, allow every request with the same 2-cycle latency and handshake.
REQ-022 SHALL implement shadow FSM IDLE/PENDING: cfg_update_i in IDLE with S1,S2 empty loads shadow next edge, stays IDLE; otherwise enters PENDING.
REQ-023 SHALL in PENDING deassert req_ready_o, load shadow on the first cycle S1 and S2 are both empty, return to IDLE; cfg_update_i in PENDING is absorbed.
REQ-024 SHALL ignore cfg_update_i coincident with a request being accepted only for that request: request is accepted, reload pends until drained.

Reset
REQ-025 SHALL on rst_ni low at clock edge clear S1/S2 valids, rsp_valid_o=0, rsp_allow_o=0, rsp_hit_o=0, rsp_idx_o=0, FSM=IDLE, shadow cfg=OFF/zero addr, viol_cnt_o=0.
REQ-026 SHALL drop in-flight requests on reset mid-operation; req_ready_o=1 the first cycle after reset releases.

Configuration
REQ-027 SHALL with PMP_VIOLATION_CNT_EN defined count each consumed response with rsp_allow_o=0 in viol_cnt_o, saturating at 16'hFFFF.
REQ-028 SHALL without PMP_VIOLATION_CNT_EN tie viol_cnt_o to 0 and infer no counter flops.

Verification
REQ-029 SHALL verify: entry0 NAPOT 0x8000_0000/4KiB RW unlocked, U-mode read 0x8000_0010 size 3 -> allow=1, hit=1, idx=0 two cycles later.
REQ-030 SHALL verify: same config, U-mode 8-byte read at 0x8000_0FFC -> partial hit, allow=0, hit=1, idx=0.
REQ-031 SHALL verify: no entries enabled, M-mode write 0x0 -> allow=1, hit=0; U-mode -> allow=0.
REQ-032 SHALL verify: entry1 locked TOR [0x1000,0x2000) R-only, M-mode write 0x1800 -> allow=0, idx=1; violation count 1 with macro, 0 without.
REQ-033 SHALL verify: rsp_ready_i low 5 cycles with 3 requests streamed -> req_ready_o drops, responses held stable, then delivered in order with no loss.
REQ-034 SHALL verify: cfg_update_i while 2 requests in flight -> those use old config, req_ready_o low until drained, next request uses new config.
